// File: rtl/transmitter_i2s.sv
// I2S master transmitter: stereo PCM pairs in, MSB-first serial out.
// Build option: TRANSMITTER_I2S_REPEAT_EN resends the last pair on underrun.
module transmitter_i2s #(
  parameter int DATA_SIZE = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] left_data,
  input  logic [DATA_SIZE-1:0] right_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 i2s_sck,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 underrun
);

  localparam int FW = 2 * DATA_SIZE;
  localparam int BW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_MAX   = BW'(FW - 1);
  localparam logic [BW-1:0] WS_LO   = BW'(DATA_SIZE - 1);
  localparam logic [BW-1:0] WS_HI   = BW'(FW - 2);

  logic          full;
  logic [FW-1:0] hold;
  logic [FW-1:0] shreg;
  logic [FW-1:0] fill;
  logic [FW-1:0] frame;
  logic          run;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] b;

  logic div_wrap;
  logic start_ev;
  logic fall_ev;
  logic shift_ev;
  logic frame_start;
  logic load_ev;
  logic starve;

  assign in_ready = !full;

`ifdef TRANSMITTER_I2S_REPEAT_EN
  logic [FW-1:0] last;

  // remember the most recently transmitted pair for repeat-on-underrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= '0;
    end else if (load_ev) begin
      last <= hold;
    end
  end

  assign fill = last;
`else
  assign fill = '0;
`endif

  // shift/frame event decode
  always_comb begin
    div_wrap    = (div_cnt == DIV_MAX);
    start_ev    = en && !run;
    fall_ev     = en && run && div_wrap && i2s_sck;
    shift_ev    = start_ev || fall_ev;
    frame_start = shift_ev && (b == '0);
    load_ev     = frame_start && full;
    starve      = frame_start && !full;
    frame       = full ? hold : fill;
  end

  // one-deep holding register; a frame load empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      hold <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      hold <= {left_data, right_data};
    end else if (load_ev) begin
      full <= 1'b0;
    end
  end

  // SCK divider; run marks that the start event has happened
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
      run     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (div_wrap) begin
        div_cnt <= '0;
        i2s_sck <= ~i2s_sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // bit counter, shifter and registered WS/SD/underrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b        <= '0;
      shreg    <= '0;
      i2s_ws   <= 1'b0;
      i2s_sd   <= 1'b0;
      underrun <= 1'b0;
    end else if (!en) begin
      b        <= '0;
      i2s_ws   <= 1'b0;
      i2s_sd   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= starve;
      if (shift_ev) begin
        b      <= (b == B_MAX) ? '0 : b + 1'b1;
        i2s_ws <= (b >= WS_LO) && (b <= WS_HI);
        if (frame_start) begin
          i2s_sd <= frame[FW-1];
          shreg  <= {frame[FW-2:0], 1'b0};
        end else begin
          i2s_sd <= shreg[FW-1];
          shreg  <= {shreg[FW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_transmitter_i2s.sv
// Bench for transmitter_i2s: random pairs, scoreboard of accepted pairs,
// per-clock monitor against a frame-timing reference model.
module tb_transmitter_i2s;

  localparam int DS  = 16;
  localparam int CD  = 2;
  localparam int FW  = 2 * DS;
  localparam int F   = 4 * DS * CD;
  localparam int DS2 = 8;
  localparam int CD2 = 1;

`ifdef TRANSMITTER_I2S_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DS-1:0] left_data = '0;
  logic [DS-1:0] right_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, i2s_sck, i2s_ws, i2s_sd, underrun;

  logic           en2 = 1'b0;
  logic [DS2-1:0] l2 = '0;
  logic [DS2-1:0] r2 = '0;
  logic           v2 = 1'b0;
  logic           rdy2, sck2, ws2, sd2, und2;

  transmitter_i2s #(.DATA_SIZE(DS), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .left_data(left_data), .right_data(right_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .underrun(underrun)
  );

  transmitter_i2s #(.DATA_SIZE(DS2), .CLK_DIV(CD2)) dut2 (
    .clk(clk), .rst(rst), .en(en2),
    .left_data(l2), .right_data(r2),
    .in_valid(v2), .in_ready(rdy2),
    .i2s_sck(sck2), .i2s_ws(ws2), .i2s_sd(sd2),
    .underrun(und2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] d;
    int            a;
  } acc_t;

  acc_t acc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model + monitor: frame timing from the enable edge,
  // pair usage decided by the scoreboard queue
  logic [FW-1:0] cur = '0;
  logic [FW-1:0] last = '0;
  bit            run_m = 1'b0;
  int            t0 = 0;
  initial forever begin
    int e, rel, q, k;
    bit x_und, x_sck, x_ws, x_sd;
    @(posedge clk);
    e = cyc;
    cyc = cyc + 1;
    x_und = 0; x_sck = 0; x_ws = 0; x_sd = 0;
    if (rst) begin
      run_m = 0;
      last = '0;
    end else if (!en) begin
      run_m = 0;
    end else begin
      if (!run_m) begin
        run_m = 1;
        t0 = e;
      end
      rel = e - t0;
      if (rel == 0 || (rel + 1) % F == 0) begin
        if (acc_q.size() > 0 && acc_q[0].a < e) begin
          cur = acc_q[0].d;
          last = cur;
          void'(acc_q.pop_front());
        end else begin
          x_und = 1;
          cur = REP ? last : '0;
        end
      end
      q = rel + 1;
      k = (q / (2 * CD)) % FW;
      x_sck = ((q / CD) % 2) == 1;
      x_sd = cur[FW-1-k];
      x_ws = (k >= DS - 1) && (k <= FW - 2);
    end
    #1;
    chk("sck", i2s_sck, x_sck);
    chk("ws", i2s_ws, x_ws);
    chk("sd", i2s_sd, x_sd);
    chk("underrun", underrun, x_und);
    chk("in_ready", in_ready, acc_q.size() == 0);
  end

  // offer one pair; called at a negedge, returns at a negedge
  task automatic send(input logic [DS-1:0] l, input logic [DS-1:0] r);
    bit done;
    done = 0;
    left_data = l;
    right_data = r;
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (in_ready) begin
        acc_q.push_back('{d: {l, r}, a: cyc});
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout t=%0t got no in_ready required in_ready=1",
               $time);
    end
  endtask

  task automatic send_rand();
    send(16'($urandom()), 16'($urandom()));
  endtask

  task automatic run_dut2();
    logic [2*DS2-1:0] p, f;
    int k;
    p = {8'h5A, 8'hC3};
    l2 = p[15:8];
    r2 = p[7:0];
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("dut2_ready_low", rdy2, 0);
    en2 = 1'b1;
    for (int q = 1; q < 64; q++) begin
      @(posedge clk);
      #1;
      k = (q / (2 * CD2)) % (2 * DS2);
      f = (q < 32 || REP) ? p : '0;
      chk("dut2_sck", sck2, (q % 2) == 1);
      chk("dut2_sd", sd2, f[2*DS2-1-k]);
      chk("dut2_ws", ws2, (k >= DS2 - 1) && (k <= 2 * DS2 - 2));
      chk("dut2_underrun", und2, q == 32);
    end
    @(negedge clk);
    en2 = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sck", i2s_sck, 0);
    chk("rst_sd", i2s_sd, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(16'hA5C3, 16'h0F0F);
    en = 1'b1;
    repeat (2 * F + 10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    send_rand();
    en = 1'b1;
    repeat (6) send_rand();
    repeat (F) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    send_rand();
    en = 1'b1;
    send_rand();
    repeat (78) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_pair_kept", in_ready, 0);
    en = 1'b1;
    repeat (F + 20) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) en = ~en;
      if (en || acc_q.size() == 0) send_rand();
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end

    en = 1'b1;
    send_rand();
    repeat (50) @(negedge clk);
    #2;
    rst = 1'b1;
    acc_q.delete();
    en = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_sck", i2s_sck, 0);
    chk("mid_rst_ws", i2s_ws, 0);
    chk("mid_rst_sd", i2s_sd, 0);
    chk("mid_rst_underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_dut2();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
